gera_asteroides: RTL

//  Asteroid spawner; stage directly upstream of the asteroid-movement control unit. On a periodic

---
 rtl/gera_asteroides.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/gera_asteroides.sv
// rtl/gera_asteroides.sv - periodic asteroid spawner: finds the first free slot and writes a new asteroid at the screen edge
module gera_asteroides #(
  parameter int          N_ASTE       = 16,
  parameter int          ADDR_W       = 4,
  parameter int          COORD_W      = 4,
  parameter int          SPAWN_PERIOD = 1000,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable_jogo,
  input  logic               busy_move,
  input  logic               mem_loaded,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [COORD_W-1:0] mem_wr_x,
  output logic [COORD_W-1:0] mem_wr_y,
  output logic [1:0]         mem_wr_opcode,
  output logic               mem_wr_loaded,
  output logic               busy_spawn,
  output logic               spawn_done,
  output logic               mem_full,
  output logic [3:0]         db_estado
);

  localparam int                 CNT_W     = $clog2(SPAWN_PERIOD);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(N_ASTE - 1);
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [3:0] {
    INICIO     = 4'd0,
    ESPERA     = 4'd1,
    RESETA     = 4'd2,
    VERIFICA   = 4'd3,
    INCREMENTA = 4'd4,
    GERA       = 4'd5,
    ESCREVE    = 4'd6,
    SINALIZA   = 4'd7,
    CHEIA      = 4'd8
  } estado_t;

  estado_t            estado, prox_estado;
  logic [CNT_W-1:0]   contador;
  logic               pendente;
  logic               tick;
  logic [7:0]         lfsr;
  logic [COORD_W-1:0] r_coord;

  assign tick          = enable_jogo && (contador == CNT_MAX);
  assign r_coord       = lfsr[COORD_W+1:2];
  assign mem_wr_loaded = 1'b1;

  // A tick always wins over the RESETA clear so a request arriving as a scan starts is not lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador <= '0;
      pendente <= 1'b0;
    end else if (!enable_jogo) begin
      contador <= '0;
      pendente <= 1'b0;
    end else if (tick) begin
      contador <= '0;
      pendente <= 1'b1;
    end else begin
      contador <= contador + 1'b1;
      if (estado == RESETA)
        pendente <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      lfsr <= LFSR_SEED;
    else
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      estado <= INICIO;
    else
      estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    mem_we      = 1'b0;
    spawn_done  = 1'b0;
    mem_full    = 1'b0;
    busy_spawn  = 1'b1;
    db_estado   = estado;
    case (estado)
      INICIO: begin
        busy_spawn  = 1'b0;
        prox_estado = ESPERA;
      end
      ESPERA: begin
        busy_spawn = 1'b0;
        if (pendente && !busy_move && enable_jogo)
          prox_estado = RESETA;
      end
      RESETA:     prox_estado = VERIFICA;
      VERIFICA: begin
        if (!mem_loaded)
          prox_estado = GERA;
        else if (mem_addr == ADDR_LAST)
          prox_estado = CHEIA;
        else
          prox_estado = INCREMENTA;
      end
      INCREMENTA: prox_estado = VERIFICA;
      GERA:       prox_estado = ESCREVE;
      ESCREVE: begin
        mem_we      = 1'b1;
        prox_estado = SINALIZA;
      end
      SINALIZA: begin
        spawn_done  = 1'b1;
        prox_estado = ESPERA;
      end
      CHEIA: begin
        mem_full    = 1'b1;
        prox_estado = ESPERA;
      end
      default: begin
        busy_spawn  = 1'b0;
        db_estado   = 4'hF;
        prox_estado = INICIO;
      end
    endcase
  end

  // The new asteroid enters on the edge opposite to its direction of travel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr      <= '0;
      mem_wr_x      <= '0;
      mem_wr_y      <= '0;
      mem_wr_opcode <= 2'b00;
    end else begin
      case (estado)
        RESETA:     mem_addr <= '0;
        INCREMENTA: mem_addr <= mem_addr + 1'b1;
        GERA: begin
          mem_wr_opcode <= lfsr[1:0];
          case (lfsr[1:0])
            2'b00: begin mem_wr_x <= '0;        mem_wr_y <= r_coord;   end
            2'b01: begin mem_wr_x <= COORD_MAX; mem_wr_y <= r_coord;   end
            2'b10: begin mem_wr_x <= r_coord;   mem_wr_y <= '0;        end
            2'b11: begin mem_wr_x <= r_coord;   mem_wr_y <= COORD_MAX; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
